// File: rtl/minterm_extractor.sv
// Minterm extractor: sweeps every input pattern of an N_VARS-input combinational
// function, records its truth table and streams the set minterm indices out.
// Optional MINTERM_EXTRACTOR_CONST_DETECT_EN adds const_one/const_zero flags.
module minterm_extractor #(
    parameter int N_VARS = 4,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic [N_VARS-1:0]         vars_o,
    input  logic                      s_i,
    output logic [(1<<N_VARS)-1:0]    table_o,
    output logic [N_VARS:0]           count_o,
    output logic                      done,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [N_VARS-1:0]         m_index,
    output logic                      m_last,
`ifdef MINTERM_EXTRACTOR_CONST_DETECT_EN
    output logic                      const_one,
    output logic                      const_zero,
`endif
    output logic [2:0]                dbg_state
);

    // Minterm stream handshake: a transfer happens on any rising edge where
    // m_valid & m_ready; while m_valid is high and m_ready low, m_index and
    // m_last hold. m_ready has no effect while m_valid is low.

    typedef enum logic [2:0] {IDLE, APPLY, SAMPLE, EMIT, FIN} state_t;

    localparam int              TBL         = 1 << N_VARS;
    localparam logic [N_VARS:0] LAST_ROW    = (N_VARS+1)'(TBL - 1);
    localparam logic [3:0]      SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    // With no settle time a row is sampled directly, so APPLY is never entered.
    localparam state_t          ROW_ENTRY   = (SETTLE == 0) ? SAMPLE : APPLY;
`ifdef MINTERM_EXTRACTOR_CONST_DETECT_EN
    localparam logic [N_VARS:0] FULL        = (N_VARS+1)'(TBL);
`endif

    state_t            state;
    logic [N_VARS:0]   row;
    logic [3:0]        settle_cnt;
    logic [N_VARS:0]   scan_ptr;

    logic [N_VARS:0]   probe;
    logic              probe_set;
    logic              probe_last;
    logic [N_VARS:0]   count_next;

    assign dbg_state = state;

    // probe is the table position the emitter looks at this cycle: the bit just
    // after a completing transfer, or the idle scan pointer.
    always_comb begin
        probe      = m_valid ? ({1'b0, m_index} + (N_VARS+1)'(1)) : scan_ptr;
        probe_set  = table_o[probe[N_VARS-1:0]];
        probe_last = 1'b1;
        for (int j = 0; j < TBL; j++) begin
            if (j > int'(probe) && table_o[j]) probe_last = 1'b0;
        end
        count_next = count_o + (N_VARS+1)'(s_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            settle_cnt <= '0;
            scan_ptr   <= '0;
            vars_o     <= '0;
            table_o    <= '0;
            count_o    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            m_valid    <= 1'b0;
            m_index    <= '0;
            m_last     <= 1'b0;
`ifdef MINTERM_EXTRACTOR_CONST_DETECT_EN
            const_one  <= 1'b0;
            const_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ROW_ENTRY;
                        busy       <= 1'b1;
                        row        <= '0;
                        vars_o     <= '0;
                        settle_cnt <= '0;
                        table_o    <= '0;
                        count_o    <= '0;
`ifdef MINTERM_EXTRACTOR_CONST_DETECT_EN
                        const_one  <= 1'b0;
                        const_zero <= 1'b0;
`endif
                    end
                end
                APPLY: begin
                    if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
                    else settle_cnt <= settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    table_o[row[N_VARS-1:0]] <= s_i;
                    count_o                  <= count_next;
                    if (row == LAST_ROW) begin
`ifdef MINTERM_EXTRACTOR_CONST_DETECT_EN
                        const_one  <= (count_next == FULL);
                        const_zero <= (count_next == '0);
                        if (count_next == '0 || count_next == FULL) begin
`else
                        if (count_next == '0) begin
`endif
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state    <= EMIT;
                            scan_ptr <= '0;
                        end
                    end else begin
                        row        <= row + (N_VARS+1)'(1);
                        vars_o     <= vars_o + N_VARS'(1);
                        settle_cnt <= '0;
                        state      <= ROW_ENTRY;
                    end
                end
                EMIT: begin
                    if (!m_valid || m_ready) begin
                        if (m_valid && m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            state   <= FIN;
                            done    <= 1'b1;
                        end else if (probe_set) begin
                            m_valid <= 1'b1;
                            m_index <= probe[N_VARS-1:0];
                            m_last  <= probe_last;
                        end else if (probe == LAST_ROW) begin
                            m_valid <= 1'b0;
                            state   <= FIN;
                            done    <= 1'b1;
                        end else begin
                            m_valid  <= 1'b0;
                            scan_ptr <= probe + (N_VARS+1)'(1);
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_extractor.sv
// Randomized scoreboard bench for minterm_extractor: a truth-table model feeds an
// expected index queue, a negedge monitor pops and compares every transfer.
module tb_minterm_extractor;
    localparam int N   = 4;
    localparam int TBL = 16;
    localparam int W   = N + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start, busy, s_i, done, m_valid, m_ready, m_last;
    logic [N-1:0]  vars_o, m_index;
    logic [TBL-1:0] table_o;
    logic [N:0]    count_o;
    logic [2:0]    dbg_state;

    logic          start0, busy0, s0, done0, m_valid0, m_ready0, m_last0;
    logic [N-1:0]  vars0, m_index0;
    logic [TBL-1:0] table0;
    logic [N:0]    count0;
    logic [2:0]    dbg_state0;
`ifdef MINTERM_EXTRACTOR_CONST_DETECT_EN
    logic const_one, const_zero, const_one0, const_zero0;
`endif

    int            func_sel, sel0, ready_mode;
    logic [TBL-1:0] rnd_tbl, rnd_tbl0;
    int            total = 0, bad = 0;
    logic [W-1:0]  exp_q[$];
    int            cyc = 0, start_cyc = 0;
    int            done_cnt = 0, n_x = 0, first_x = 0, last_x = 0;

    function automatic logic f_eval(input int sel, input logic [N-1:0] v, input logic [TBL-1:0] t);
        case (sel)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return v[3] & ~v[0];
            3:       return v[0];
            default: return t[v];
        endcase
    endfunction

    assign s_i = f_eval(func_sel, vars_o, rnd_tbl);
    assign s0  = f_eval(sel0, vars0, rnd_tbl0);

    minterm_extractor #(.N_VARS(N), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .vars_o(vars_o),
        .s_i(s_i), .table_o(table_o), .count_o(count_o), .done(done),
        .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index), .m_last(m_last),
`ifdef MINTERM_EXTRACTOR_CONST_DETECT_EN
        .const_one(const_one), .const_zero(const_zero),
`endif
        .dbg_state(dbg_state)
    );

    minterm_extractor #(.N_VARS(N), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .vars_o(vars0),
        .s_i(s0), .table_o(table0), .count_o(count0), .done(done0),
        .m_valid(m_valid0), .m_ready(m_ready0), .m_index(m_index0), .m_last(m_last0),
`ifdef MINTERM_EXTRACTOR_CONST_DETECT_EN
        .const_one(const_one0), .const_zero(const_zero0),
`endif
        .dbg_state(dbg_state0)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, expv, cyc);
        end
    endtask

    // Ready driver: always ready, 1-0-0-1 repeating, or random.
    initial begin
        int rc;
        rc = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1: begin m_ready = (rc % 4 == 0) || (rc % 4 == 3); rc++; end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: stall stability, transfer scoreboard, done pulse count.
    initial begin
        logic         pv, pr;
        logic [W-1:0] pd, e;
        pv = 1'b0; pr = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                continue;
            end
            if (done) done_cnt++;
            if (pv && !pr) check("hold_stable", {m_valid, m_last, m_index}, {1'b1, pd});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_xfer: got index %0d last %0d, expected no transfer", m_index, m_last);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer", {m_last, m_index}, e);
                end
                if (n_x == 0) first_x = cyc;
                last_x = cyc;
                n_x++;
            end
            pv = m_valid; pr = m_ready; pd = {m_last, m_index};
        end
    end

    task automatic run_scan(input int fsel, input int rmode, input bit poke, output int rel);
        logic [TBL-1:0] et;
        int cnt, hi, waited;
        bit poked;
        func_sel = fsel; ready_mode = rmode;
        et = '0; cnt = 0; hi = -1;
        for (int p = 0; p < TBL; p++) begin
            et[p] = f_eval(fsel, 4'(p), rnd_tbl);
            if (et[p]) begin cnt++; hi = p; end
        end
`ifdef MINTERM_EXTRACTOR_CONST_DETECT_EN
        if (cnt != TBL)
`endif
        for (int p = 0; p < TBL; p++)
            if (et[p]) exp_q.push_back({1'(p == hi), 4'(p)});
        done_cnt = 0; n_x = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        start_cyc = cyc;
        rel = -1; waited = 0; poked = 0;
        while (waited < 300) begin
            if (done) begin rel = cyc - start_cyc; break; end
            @(negedge clk);
            waited++;
            start = poke && (waited == 3 || (m_valid && !poked));
            if (m_valid) poked = 1;
        end
        start = 1'b0;
        check("done_within_budget", 32'(rel >= 0), 32'd1);
        repeat (2) @(negedge clk);
        check("table", table_o, et);
        check("count", count_o, cnt);
        check("queue_drained", exp_q.size(), 0);
        check("done_once", done_cnt, 1);
        check("idle_busy", busy, 0);
        exp_q.delete();
    endtask

    initial begin
        int rel, waited;
        start = 0; start0 = 0; m_ready0 = 1'b1;
        func_sel = 1; sel0 = 1; rnd_tbl = '0; rnd_tbl0 = '0; ready_mode = 0;
        repeat (3) @(negedge clk);
        check("rst_vars", vars_o, 0);
        check("rst_table", table_o, 0);
        check("rst_count", count_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(0, 0, 0, rel);
`ifdef MINTERM_EXTRACTOR_CONST_DETECT_EN
        check("taut_done_at_32", rel, 32);
        check("taut_const_one", const_one, 1);
        check("taut_const_zero", const_zero, 0);
`else
        check("taut_consecutive", last_x - first_x, 15);
        check("taut_done_after_last", start_cyc + rel - last_x, 1);
`endif
        run_scan(1, 0, 0, rel);
        check("zero_done_at_32", rel, 32);
`ifdef MINTERM_EXTRACTOR_CONST_DETECT_EN
        check("zero_const_zero", const_zero, 1);
`endif
        run_scan(2, 0, 0, rel);
        run_scan(3, 1, 1, rel);
        check("bp_xfers", n_x, 8);
        for (int i = 0; i < 4; i++) begin
            rnd_tbl = 16'($urandom);
            run_scan(4, $urandom_range(0, 2), 1'(i), rel);
        end

        // Asynchronous reset during row 7 of a scan.
        rnd_tbl = 16'($urandom) | 16'h0001;
        func_sel = 4; ready_mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        waited = 0;
        while (vars_o != 4'd7 && waited < 100) begin @(negedge clk); waited++; end
        check("reach_row7", vars_o, 7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vars", vars_o, 0);
        check("arst_table", table_o, 0);
        check("arst_count", count_o, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_valid", m_valid, 0);
        check("arst_index", m_index, 0);
        check("arst_last", m_last, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_scan(4, 2, 0, rel);

        // SETTLE=0 instance: zero function gives a 16-cycle scan, then a random table.
        for (int k = 0; k < 2; k++) begin
            int c0;
            sel0 = (k == 0) ? 1 : 4;
            rnd_tbl0 = 16'($urandom) & 16'h7FFF;
            @(negedge clk) start0 = 1'b1;
            @(negedge clk) start0 = 1'b0;
            c0 = cyc; waited = 0;
            while (!done0 && waited < 200) begin @(negedge clk); waited++; end
            if (k == 0) check("settle0_len", cyc - c0, 16);
            else check("settle0_done_seen", done0, 1);
            @(negedge clk);
            check("settle0_table", table0, (k == 0) ? 16'h0000 : rnd_tbl0);
            check("settle0_count", count0, (k == 0) ? 0 : $countones(rnd_tbl0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
